// File: rtl/frame_chk_pkg.sv
// Shared constants and types for the frame checksum monitor.
// Frame geometry, the result-register state and the per-frame result record.
package frame_chk_pkg;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 4;
  localparam int SUM_W     = DATA_W + CNT_W;
  localparam int ID_W      = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  typedef struct packed {
    logic [SUM_W-1:0]  sum;
    logic [DATA_W-1:0] chk_xor;
    logic [ID_W-1:0]   id;
  } result_t;

endpackage

// File: rtl/frame_result_reg.sv
// Single-entry holding register for frame results, with drop detection.
// Counts frames that complete while the held result has not been taken.
module frame_result_reg
  import frame_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  result_t    load_data,
  input  logic       out_ready,
  input  logic       clear_stat,
  output out_state_t state,
  output result_t    held,
  output logic       overrun,
  output logic [7:0] drop_cnt
);

  // Valid/ready: valid is (state == FULL); a transfer happens on a rising
  // edge where valid && out_ready. While valid && !out_ready, held is stable.
  out_state_t state_next;
  logic       accept;
  logic       drop;

  assign accept = load && ((state == EMPTY) || out_ready);
  assign drop   = load && (state == FULL) && !out_ready;

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (load) state_next = FULL;
      FULL: begin
        if (load)           state_next = FULL;
        else if (out_ready) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      held  <= '0;
    end else begin
      state <= state_next;
      if (accept) held <= load_data;
    end
  end

  // A drop in the same cycle as clear_stat wins, leaving a count of one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overrun <= 1'b1;
      if (clear_stat)              drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF)  drop_cnt <= drop_cnt + 8'd1;
    end else if (clear_stat) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end
  end

endmodule

// File: rtl/frame_checksum_monitor.sv
// Accumulates fixed-length byte frames into a sum and an XOR checksum and
// presents each frame result on a valid/ready port.
module frame_checksum_monitor
  import frame_chk_pkg::result_t;
  import frame_chk_pkg::out_state_t;
  import frame_chk_pkg::FULL;
#(
  parameter int DATA_W    = frame_chk_pkg::DATA_W,
  parameter int FRAME_LEN = frame_chk_pkg::FRAME_LEN,
  parameter int CNT_W     = frame_chk_pkg::CNT_W,
  parameter int SUM_W     = frame_chk_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  input  logic              clear_stat,
  output logic              out_valid,
  output logic [SUM_W-1:0]  out_sum,
  output logic [DATA_W-1:0] out_xor,
  output logic [7:0]        out_frame_id,
  output logic [CNT_W-1:0]  byte_idx,
  output logic              overrun,
  output logic [7:0]        drop_cnt
);

  logic [CNT_W-1:0]  idx_q;
  logic [SUM_W-1:0]  acc_sum;
  logic [DATA_W-1:0] acc_xor;
  logic [7:0]        frame_ctr;
  logic              last_byte;
  result_t           final_res;
  result_t           held;
  out_state_t        res_state;

  assign last_byte = in_valid && (idx_q == CNT_W'(FRAME_LEN - 1));

  // The running values including the current byte; on the last byte this is
  // the frame result, otherwise it is the next accumulator value.
  always_comb begin
    final_res         = '0;
    final_res.sum     = acc_sum + SUM_W'(in_data);
    final_res.chk_xor = acc_xor ^ in_data;
    final_res.id      = frame_ctr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      acc_sum   <= '0;
      acc_xor   <= '0;
      frame_ctr <= '0;
    end else if (in_valid) begin
      if (last_byte) begin
        idx_q     <= '0;
        acc_sum   <= '0;
        acc_xor   <= '0;
        frame_ctr <= frame_ctr + 8'd1;
      end else begin
        idx_q   <= idx_q + CNT_W'(1);
        acc_sum <= final_res.sum;
        acc_xor <= final_res.chk_xor;
      end
    end
  end

  frame_result_reg u_result (
    .clk        (clk),
    .rst        (rst),
    .load       (last_byte),
    .load_data  (final_res),
    .out_ready  (out_ready),
    .clear_stat (clear_stat),
    .state      (res_state),
    .held       (held),
    .overrun    (overrun),
    .drop_cnt   (drop_cnt)
  );

  assign out_valid    = (res_state == FULL);
  assign out_sum      = held.sum;
  assign out_xor      = held.chk_xor;
  assign out_frame_id = held.id;
  assign byte_idx     = idx_q;

endmodule

// File: tb/tb_frame_checksum_monitor.sv
// Directed bench for frame_checksum_monitor: expected frame results go into
// a queue and are compared whenever a result transfers on the output port.
module tb_frame_checksum_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        out_ready;
  logic        clear_stat;
  logic        out_valid;
  logic [11:0] out_sum;
  logic [7:0]  out_xor;
  logic [7:0]  out_frame_id;
  logic [3:0]  byte_idx;
  logic        overrun;
  logic [7:0]  drop_cnt;

  logic [27:0] exp_q[$];
  logic [27:0] mon_e;
  int          n_checks = 0;
  int          n_pass   = 0;

  frame_checksum_monitor dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_ready    (out_ready),
    .clear_stat   (clear_stat),
    .out_valid    (out_valid),
    .out_sum      (out_sum),
    .out_xor      (out_xor),
    .out_frame_id (out_frame_id),
    .byte_idx     (byte_idx),
    .overrun      (overrun),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_exp(input logic [11:0] s, input logic [7:0] x, input logic [7:0] id);
    exp_q.push_back({s, x, id});
  endtask

  task automatic send_byte(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_const(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) send_byte(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Scoreboard: a result leaves the DUT on the next edge whenever valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got sum=%0h xor=%0h id=%0h expected none",
                 out_sum, out_xor, out_frame_id);
      end else begin
        mon_e = exp_q.pop_front();
        check("res_sum", 32'(out_sum), 32'(mon_e[27:16]));
        check("res_xor", 32'(out_xor), 32'(mon_e[15:8]));
        check("res_id",  32'(out_frame_id), 32'(mon_e[7:0]));
      end
    end
  end

  initial begin
    int v;
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    clear_stat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_xor", 32'(out_xor), 0);
    check("rst_out_frame_id", 32'(out_frame_id), 0);
    check("rst_byte_idx", 32'(byte_idx), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);

    // Ramp 1..16: sum 0x88, xor 0x10.
    out_ready = 1'b1;
    push_exp(12'h088, 8'h10, 8'd0);
    for (int i = 1; i <= 16; i++) begin
      send_byte(8'(i));
      if (i == 15) check("t1_valid_before_last", 32'(out_valid), 0);
    end
    check("t1_valid_after_last", 32'(out_valid), 1);
    check("t1_byte_idx_wrap", 32'(byte_idx), 0);

    // All 0xFF: sum 0xFF0 without overflow, xor 0.
    push_exp(12'hFF0, 8'h00, 8'd1);
    send_const(8'hFF, 16);
    idle(2);

    // Back-to-back frames with no consumer: second one is dropped.
    do_reset();
    out_ready = 1'b0;
    push_exp(12'h030, 8'h00, 8'd0);
    send_const(8'h03, 16);
    send_const(8'h05, 16);
    check("t3_valid_held", 32'(out_valid), 1);
    check("t3_held_id", 32'(out_frame_id), 0);
    check("t3_held_sum", 32'(out_sum), 32'h030);
    check("t3_overrun", 32'(overrun), 1);
    check("t3_drop_cnt", 32'(drop_cnt), 1);
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    check("t3_valid_drained", 32'(out_valid), 0);
    clear_stat = 1'b1;
    idle(1);
    clear_stat = 1'b0;
    check("t3_clear_overrun", 32'(overrun), 0);
    check("t3_clear_drop_cnt", 32'(drop_cnt), 0);
    push_exp(12'h110, 8'h00, 8'd2);
    send_const(8'h11, 16);
    check("t3_next_id", 32'(out_frame_id), 2);

    // Handshake on the completion cycle of the next frame: no drop.
    push_exp(12'h010, 8'h00, 8'd3);
    send_const(8'h01, 15);
    out_ready = 1'b1;
    send_byte(8'h01);
    out_ready = 1'b0;
    check("t4_valid_stays", 32'(out_valid), 1);
    check("t4_id", 32'(out_frame_id), 3);
    check("t4_overrun", 32'(overrun), 0);
    check("t4_drop_cnt", 32'(drop_cnt), 0);
    out_ready = 1'b1;
    idle(1);
    check("t4_drained", 32'(out_valid), 0);

    // Alternating in_valid: only valid cycles advance the frame.
    push_exp(12'h088, 8'h10, 8'd4);
    v = 0;
    for (int i = 0; i < 32; i++) begin
      if (i % 2 == 0) begin
        in_valid = 1'b1;
        in_data  = 8'(v + 1);
        v++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("t5_byte_idx", 32'(byte_idx), 32'(v % 16));
      check("t5_out_valid", 32'(out_valid), (i == 30) ? 32'd1 : 32'd0);
    end
    idle(2);

    // Reset mid-frame discards the partial frame.
    send_const(8'h09, 7);
    check("t6_idx_before_rst", 32'(byte_idx), 7);
    do_reset();
    check("t6_idx_after_rst", 32'(byte_idx), 0);
    check("t6_valid_after_rst", 32'(out_valid), 0);
    push_exp(12'h020, 8'h00, 8'd0);
    send_const(8'h02, 16);
    idle(1);

    // Saturate drop_cnt, then clear; then a drop coinciding with clear_stat.
    out_ready = 1'b0;
    push_exp(12'h070, 8'h00, 8'd1);
    send_const(8'h07, 16);
    for (int f = 0; f < 255; f++) send_const(8'h00, 16);
    check("sat_drop_cnt_255", 32'(drop_cnt), 255);
    check("sat_overrun", 32'(overrun), 1);
    send_const(8'h00, 16);
    check("sat_drop_cnt_hold", 32'(drop_cnt), 255);
    clear_stat = 1'b1;
    idle(1);
    clear_stat = 1'b0;
    check("sat_clear_drop_cnt", 32'(drop_cnt), 0);
    check("sat_clear_overrun", 32'(overrun), 0);
    send_const(8'h00, 15);
    clear_stat = 1'b1;
    send_byte(8'h00);
    clear_stat = 1'b0;
    check("clr_drop_prio_cnt", 32'(drop_cnt), 1);
    check("clr_drop_prio_overrun", 32'(overrun), 1);
    check("held_id_after_drops", 32'(out_frame_id), 1);
    out_ready = 1'b1;
    idle(1);
    check("final_drained", 32'(out_valid), 0);
    idle(2);
    check("queue_empty", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/frame_checksum_monitor.md
Name: frame_checksum_monitor

Overview:
- Downstream consumer of the 16-entry byte buffer's read port (data_out).
- Groups the incoming byte stream into fixed frames of FRAME_LEN bytes and computes two checksums per frame: a running sum and a running XOR.
- Presents each frame result on a valid/ready output port, with drop counting and a sticky overrun flag.
- Default FRAME_LEN=16 matches the buffer's 4-bit pointer wrap, so frame boundaries align with pointer wrap-around.

Parameters:
- DATA_W, 8, width of input data bytes.
- FRAME_LEN, 16, bytes per frame; power of two, at least 2.
- CNT_W, 4, log2(FRAME_LEN); width of the byte-index counter.
- SUM_W, 12, DATA_W+CNT_W; sum width, so the sum never overflows within a frame.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data carries a byte this cycle; no backpressure on the input side.
- in_data  in  DATA_W  byte from the upstream buffer read port.
- out_ready  in  1  consumer accepts the result this cycle.
- clear_stat  in  1  synchronous clear of overrun and drop_cnt.
- out_valid  out  1  a frame result is held on out_sum, out_xor and out_frame_id.
- out_sum  out  SUM_W  unsigned sum of the frame's bytes.
- out_xor  out  DATA_W  bitwise XOR of the frame's bytes.
- out_frame_id  out  8  frame sequence number; wraps 255 -> 0.
- byte_idx  out  CNT_W  index of the next byte within the current frame.
- overrun  out  1  sticky; set when a completed frame is dropped.
- drop_cnt  out  8  number of dropped frames; saturates at 255.

Behaviour:
- Reset (asynchronous, rst=1): all outputs 0; internal accumulators 0; internal frame counter 0.
- Byte acceptance: a byte is accepted on every cycle with in_valid=1. Input is never stalled.
- Accumulation:
  - If byte_idx != FRAME_LEN-1: acc_sum <= acc_sum + in_data (zero-extended to SUM_W); acc_xor <= acc_xor ^ in_data; byte_idx++.
  - If byte_idx == FRAME_LEN-1 (last byte): final = (acc_sum+in_data, acc_xor^in_data). Accumulators clear to 0 and byte_idx wraps to 0 in the same cycle.
  - The next frame's first byte can arrive on the very next cycle; there are no bubbles.
- Latency: last byte accepted on edge N; out_valid=1 with the result visible after edge N. Sum and XOR include the last byte.
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1; holds the result.
  - Handshake: transfer occurs when out_valid && out_ready. Data is stable while out_valid && !out_ready.
- Transitions on frame completion (final):
  - EMPTY -> FULL: load final; out_frame_id <= frame_ctr; frame_ctr++.
  - FULL with out_ready=1 (simultaneous completion and handshake): load final and stay FULL. No overrun.
  - FULL with out_ready=0: drop final and keep the held result. overrun<=1; drop_cnt++ (saturating); frame_ctr++, so the dropped frame consumes an id.
- Without frame completion: FULL with out_ready=1 -> EMPTY.
- clear_stat: overrun<=0, drop_cnt<=0.
  - If a drop occurs in the same cycle, the drop takes priority: overrun=1 and drop_cnt=1.
- in_valid=0: no state change in the accumulators.
- Reset mid-frame: the partial frame is discarded; the next accepted byte is index 0.

Decomposition:
- Shared package frame_chk_pkg:
  - FRAME_LEN, CNT_W, SUM_W constants.
  - Output-register state enum {EMPTY, FULL}.
  - Packed struct {sum, xor, id} for the result.
- One sub-module, frame_result_reg: the single-entry valid/ready holding register with drop detection and outputs overrun and drop_cnt. The accumulators stay in the top module.

Test Plan:
1. Reset, then 16 bytes 0x01..0x10 with in_valid held 1, out_ready=1 -> one cycle after the 16th byte: out_valid=1, out_sum=0x088, out_xor=0x10, out_frame_id=0.
2. 16 bytes of 0xFF -> out_sum=0xFF0 (no overflow), out_xor=0x00.
3. Two back-to-back frames with out_ready=0 -> first result held (id 0); second dropped; overrun=1, drop_cnt=1. Then out_ready=1 for one cycle -> out_valid=0. The next frame reports out_frame_id=2.
4. out_ready=1 pulsed exactly on the completion cycle of frame 1 while frame 0 is held -> frame 0 handshakes, frame 1 loads, out_valid stays 1, overrun=0.
5. Bytes with in_valid toggling 1,0,1,0 over 32 cycles -> frame completes only after the 16th valid byte; byte_idx advances only on valid cycles.
6. rst asserted after 7 bytes, then 16 bytes of 0x02 -> out_sum=0x020, out_xor=0x00, out_frame_id=0. Also: drop_cnt driven to 255 then one more drop -> stays 255; clear_stat -> 0.
